// File: rtl/fp_accumulator_sequential.sv
// Multi-cycle fp32 accumulator (truncating, no denormals) fed by the sequential multiplier.
// Optional accepted-operand counter enabled by defining FP_ACC_COUNT_EN.
module fp_accumulator_sequential (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_overflow,
    output logic [31:0] acc_out,
    output logic        overflow,
    output logic        done
`ifdef FP_ACC_COUNT_EN
   ,output logic [15:0] count
`endif
);

    // UNPACK is the capture cycle after accept; it gives the 5+k accept-to-result latency.
    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_WRITE
    } state_t;

    state_t      state, state_nx;
    logic [31:0] opnd;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        inf_flag, inf_sign;
    logic        sgn;
    logic [7:0]  exp;
    logic [24:0] sum;
    logic [31:0] res;
    logic        res_ovf;
    logic        accept;
    logic        norm_done;
    logic [7:0]  xa, xb, diff;
    logic [23:0] fa, fb;

    assign in_ready  = (state == S_IDLE);
    assign accept    = in_valid & in_ready & ~clear;
    assign xa        = acc_out[30:23];
    assign xb        = opnd[30:23];
    assign fa        = (xa != 8'd0) ? {1'b1, acc_out[22:0]} : '0;
    assign fb        = (xb != 8'd0) ? {1'b1, opnd[22:0]} : '0;
    assign diff      = ea - eb;
    assign norm_done = (sum == '0) | sum[24] | sum[23] | (exp <= 8'd1);

    always_ff @(posedge clk) begin
        if (rst || clear) state <= S_IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_UNPACK;
            S_UNPACK: state_nx = S_ALIGN;
            S_ALIGN:  state_nx = S_ADD;
            S_ADD:    state_nx = S_NORM;
            S_NORM:   if (norm_done) state_nx = S_WRITE;
            S_WRITE:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == S_WRITE);
            if (accept && in_overflow) overflow <= 1'b1;
            if (state == S_WRITE) begin
                acc_out <= res;
                if (res_ovf) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (accept) opnd <= in_data;
            S_UNPACK: begin
                // Operand with the larger exponent goes to the 'a' side.
                if (xb > xa) begin
                    sa <= opnd[31];    ea <= xb; ma <= fb;
                    sb <= acc_out[31]; eb <= xa; mb <= fa;
                end else begin
                    sa <= acc_out[31]; ea <= xa; ma <= fa;
                    sb <= opnd[31];    eb <= xb; mb <= fb;
                end
                inf_flag <= (xb == 8'hFF) | (xa == 8'hFF);
                inf_sign <= (xb == 8'hFF) ? opnd[31] : acc_out[31];
            end
            S_ALIGN: begin
                if (diff >= 8'd25) mb <= '0;
                else               mb <= mb >> diff;
            end
            S_ADD: begin
                exp <= ea;
                if (sa == sb) begin
                    sum <= {1'b0, ma} + {1'b0, mb};
                    sgn <= sa;
                end else if (ma >= mb) begin
                    sum <= {1'b0, ma} - {1'b0, mb};
                    sgn <= sa;
                end else begin
                    sum <= {1'b0, mb} - {1'b0, ma};
                    sgn <= sb;
                end
            end
            S_NORM: begin
                res_ovf <= 1'b0;
                if (sum == '0) begin
                    res <= '0;
                end else if (sum[24]) begin
                    if (exp == 8'hFE) begin
                        res     <= {sgn, 8'hFF, 23'h0};
                        res_ovf <= 1'b1;
                    end else begin
                        res <= {sgn, exp + 8'd1, sum[23:1]};
                    end
                end else if (!sum[23]) begin
                    if (exp <= 8'd1) begin
                        res <= '0;
                    end else begin
                        sum <= {sum[23:0], 1'b0};
                        exp <= exp - 8'd1;
                    end
                end else begin
                    res <= {sgn, exp, sum[22:0]};
                end
                if (inf_flag) begin
                    res     <= {inf_sign, 8'hFF, 23'h0};
                    res_ovf <= 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef FP_ACC_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || clear)                    count <= '0;
        else if (accept && count != 16'hFFFF) count <= count + 16'd1;
    end
`endif

endmodule
